fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Initiator side of the imem read interface (addr/enable/data/ready); imem is the responder.
//  Holds the PC and issues one instruction read at a time.
//  Buffers returned instructions in a small FIFO toward decode.
//  Handles PC redirects from execute, squashing any in-flight read.
// PARAMETERS
//  RESET_PC    0   PC loaded on reset; first fetch address
//  PC_INC      4   PC increment per sequential fetch (bytes)
//  FIFO_DEPTH  2   instruction buffer entries (power of 2, >=2)
// PORTS
//  clk             in   1               clock, all logic on posedge
//  reset           in   1               asynchronous, active-high reset
//  imem_rd_addr    out  `ADDR_SIZE+1    read address, stable while enable high
//  imem_rd_enable  out  1               read request
//  imem_rd_data    in   `INSTR_SIZE+1   read data, valid when ready high
//  imem_rd_ready   in   1               read completes this cycle
//  redirect_valid  in   1               branch/jump taken: restart fetch
//  redirect_pc     in   `ADDR_SIZE+1    new fetch PC
//  instr_valid     out  1               FIFO head valid
//  instr           out  `INSTR_SIZE+1   FIFO head instruction
//  instr_pc        out  `ADDR_SIZE+1    FIFO head PC
//  instr_ready     in   1               decode pops head when valid&ready
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, enable=0, addr=RESET_PC, FIFO empty (instr_valid=0), state=IDLE.
//  Handshake: once enable raised, addr and enable held until ready sampled high; at most one
//   outstanding read; ready while enable low is ignored. Data captured on the ready cycle.
//  Credit: issue only if fifo_count + outstanding < FIFO_DEPTH (same-cycle pop not counted).
//  States:
//   IDLE   enable=0. Credit available -> REQ (enable=1, addr=pc) next cycle.
//   REQ    waiting ready. ready&!redirect: push {data,addr}, pc+=PC_INC; credit left -> REQ at
//          new pc (back-to-back, 1 read/2 cycles min with 1-cycle imem), else IDLE.
//          redirect&!ready -> SQUASH, pc=redirect_pc. redirect&ready -> data dropped,
//          pc=redirect_pc, -> REQ at redirect_pc.
//   SQUASH enable/addr still held for the old read; ready -> data dropped, -> REQ at pc.
//          Further redirect here: pc updated to newest redirect_pc, stay SQUASH.
//  Latency: reset deassert -> enable high next posedge; ready -> instr_valid next cycle.
//  Redirect: FIFO flushed the same edge (instr_valid=0 next cycle); flush beats a same-cycle
//   push or pop. No instruction fetched before redirect is ever delivered after it.
//  FIFO full: no new request; an outstanding read always has a free slot by credit rule.
//  PC arithmetic: modulo 2^(`ADDR_SIZE+1), wrap silently; no alignment check.
//  Reset mid-read: everything cleared immediately; in-flight response ignored (enable=0).
// STRUCTURE
//  Widths from `ADDR_SIZE/`INSTR_SIZE in def_params.v; add `RESET_PC default and state
//   encodings (FU_IDLE/FU_REQ/FU_SQUASH) there.
//  Sub-module fetch_fifo: sync FIFO, width `ADDR_SIZE+`INSTR_SIZE+2, depth FIFO_DEPTH,
//   push/pop/flush, count output, async reset.
//  Top: FSM + PC register + credit logic + fetch_fifo instance.
// TESTING
//  Bench: imem model with configurable ready latency (1..3 cycles), data = addr^32'hA5A5_0000.
//  1 Reset release, instr_ready=1, latency 1 -> addrs 0,4,8,... ; instr/instr_pc pairs in order.
//  2 instr_ready=0 -> exactly FIFO_DEPTH=2 entries (pc 0,4) then enable low; ready=1 -> resumes at 8.
//  3 Redirect to 0x100 while read of 0x8 pending (latency 3) -> addr held at 0x8 until ready,
//    its data dropped, next addr 0x100, first delivered instr_pc=0x100.
//  4 Redirect to 0x200 on the same cycle as ready -> no SQUASH cycle, next addr 0x200, FIFO empty.
//  5 Two redirects (0x300 then 0x400) during SQUASH -> only 0x400 fetched; no 0x300 delivered.
//  6 Reset asserted mid-read, ready returns later -> outputs at reset values, stray ready ignored,
//    refetch from RESET_PC; PC at 0xFFFF_FFFC wraps to 0x0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared widths, state encoding and PC helper for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned ADDR_SIZE  = 31;
  localparam int unsigned INSTR_SIZE = 31;
  localparam int unsigned ADDR_W     = ADDR_SIZE + 1;
  localparam int unsigned INSTR_W    = INSTR_SIZE + 1;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    FuIdle   = 2'd0,
    FuReq    = 2'd1,
    FuSquash = 2'd2
  } fu_state_e;

  // Wraps modulo 2^ADDR_W; no alignment is enforced.
  function automatic logic [ADDR_W-1:0] pc_add(input logic [ADDR_W-1:0] pc,
                                               input logic [ADDR_W-1:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {instr, pc} pairs toward decode; flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != CntW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem read handshake, redirect squash, decode buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [ADDR_W-1:0] PC_INC     = ADDR_W'(4),
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_rd_addr,
  output logic               imem_rd_enable,
  input  logic [INSTR_W-1:0] imem_rd_data,
  input  logic               imem_rd_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  fu_state_e                 r_state, w_state_nxt;
  logic [ADDR_W-1:0]         r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]         r_addr, w_addr_nxt;
  logic                      w_push, w_pop;
  logic [CntW-1:0]           w_count;
  logic [INSTR_W+ADDR_W-1:0] w_head;
  logic                      w_credit_idle, w_credit_after_push;

  // Credit ignores a same-cycle pop; an outstanding read always owns a slot.
  assign w_credit_idle       = w_count < DepthC;
  assign w_credit_after_push = (w_count + CntW'(1)) < DepthC;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    unique case (r_state)
      FuIdle: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_addr_nxt  = redirect_pc;
          w_state_nxt = FuReq;
        end else if (w_credit_idle) begin
          w_addr_nxt  = r_pc;
          w_state_nxt = FuReq;
        end
      end
      FuReq: begin
        if (imem_rd_ready) begin
          if (redirect_valid) begin
            w_pc_nxt   = redirect_pc;
            w_addr_nxt = redirect_pc;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = pc_add(r_pc, PC_INC);
            if (w_credit_after_push) w_addr_nxt = w_pc_nxt;
            else                     w_state_nxt = FuIdle;
          end
        end else if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = FuSquash;
        end
      end
      FuSquash: begin
        if (redirect_valid) w_pc_nxt = redirect_pc;
        if (imem_rd_ready) begin
          w_addr_nxt  = w_pc_nxt;
          w_state_nxt = FuReq;
        end
      end
      default: w_state_nxt = FuIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FuIdle;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign imem_rd_enable = (r_state != FuIdle);
  assign imem_rd_addr   = r_addr;
  assign w_pop          = instr_valid && instr_ready;

  fetch_fifo #(
    .WIDTH(INSTR_W + ADDR_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_data ({imem_rd_data, r_addr}),
    .i_pop  (w_pop),
    .i_flush(redirect_valid),
    .o_head (w_head),
    .o_count(w_count)
  );

  assign instr_valid      = (w_count != '0);
  assign {instr, instr_pc} = w_head;

endmodule
